// File: rtl/dispatch_ctrl_pkg.sv
// Shared types for the decode/dispatch slice.
// Contents: instruction-class, ALU-function and branch-function enums,
// the decoded-instruction record, unit encodings, dispatch FSM state
// codes and the iType -> execution-unit mapping.
package dispatch_ctrl_pkg;

  typedef enum logic [3:0] {
    IT_NOP    = 4'd0,
    IT_OP     = 4'd1,
    IT_OPIMM  = 4'd2,
    IT_LUI    = 4'd3,
    IT_AUIPC  = 4'd4,
    IT_BRANCH = 4'd5,
    IT_JAL    = 4'd6,
    IT_JALR   = 4'd7,
    IT_LOAD   = 4'd8,
    IT_STORE  = 4'd9
  } iType_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } aluFunc_t;

  typedef enum logic [2:0] {
    BR_EQ   = 3'd0,
    BR_NE   = 3'd1,
    BR_LT   = 3'd2,
    BR_GE   = 3'd3,
    BR_LTU  = 3'd4,
    BR_GEU  = 3'd5,
    BR_JAL  = 3'd6,
    BR_JALR = 3'd7
  } brFunc_t;

  typedef struct packed {
    iType_t      iType;
    aluFunc_t    aluFunc;
    brFunc_t     brFunc;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } decode_t;

  localparam logic [1:0] UNIT_ALU = 2'd0;
  localparam logic [1:0] UNIT_BR  = 2'd1;
  localparam logic [1:0] UNIT_MEM = 2'd2;

  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_WAIT_BR = 1'b1;

  // NOP has no real unit; callers drop it before this result matters.
  function automatic logic [1:0] unitOf(input iType_t t);
    case (t)
      IT_BRANCH, IT_JAL, IT_JALR: unitOf = UNIT_BR;
      IT_LOAD, IT_STORE:          unitOf = UNIT_MEM;
      default:                    unitOf = UNIT_ALU;
    endcase
  endfunction

endpackage

// File: rtl/dispatch_ctrl_decode.sv
// RV32I base decoder (combinational).
// Ports:
//   i_inst  32-bit instruction word
//   o_dec   decoded record: class, ALU/branch function, immediate, reg indices
// Unrecognised opcodes decode as IT_NOP.
module dispatch_ctrl_decode
  import dispatch_ctrl_pkg::*;
(
  input  logic [31:0] i_inst,
  output decode_t     o_dec
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic       w_f7b5;

  assign w_opcode = i_inst[6:0];
  assign w_funct3 = i_inst[14:12];
  assign w_f7b5   = i_inst[30];

  // Register fields are passed through raw; consumers ignore unused ones.
  always_comb begin
    o_dec         = '0;
    o_dec.iType   = IT_NOP;
    o_dec.aluFunc = ALU_ADD;
    o_dec.brFunc  = BR_EQ;
    o_dec.rs1     = i_inst[19:15];
    o_dec.rs2     = i_inst[24:20];
    o_dec.rd      = i_inst[11:7];
    case (w_opcode)
      7'b0110011: o_dec.iType = IT_OP;
      7'b0010011: o_dec.iType = IT_OPIMM;
      7'b0110111: o_dec.iType = IT_LUI;
      7'b0010111: o_dec.iType = IT_AUIPC;
      7'b1100011: o_dec.iType = IT_BRANCH;
      7'b1101111: o_dec.iType = IT_JAL;
      7'b1100111: o_dec.iType = IT_JALR;
      7'b0000011: o_dec.iType = IT_LOAD;
      7'b0100011: o_dec.iType = IT_STORE;
      default:    o_dec.iType = IT_NOP;
    endcase

    case (o_dec.iType)
      IT_OPIMM, IT_JALR, IT_LOAD:
        o_dec.imm = {{20{i_inst[31]}}, i_inst[31:20]};
      IT_STORE:
        o_dec.imm = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
      IT_BRANCH:
        o_dec.imm = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
      IT_LUI, IT_AUIPC:
        o_dec.imm = {i_inst[31:12], 12'b0};
      IT_JAL:
        o_dec.imm = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
      default:
        o_dec.imm = '0;
    endcase

    // SUB only exists for register-register ops; SRA uses bit 30 in both forms.
    if (o_dec.iType == IT_OP || o_dec.iType == IT_OPIMM) begin
      case (w_funct3)
        3'b000:  o_dec.aluFunc = (o_dec.iType == IT_OP && w_f7b5) ? ALU_SUB : ALU_ADD;
        3'b001:  o_dec.aluFunc = ALU_SLL;
        3'b010:  o_dec.aluFunc = ALU_SLT;
        3'b011:  o_dec.aluFunc = ALU_SLTU;
        3'b100:  o_dec.aluFunc = ALU_XOR;
        3'b101:  o_dec.aluFunc = w_f7b5 ? ALU_SRA : ALU_SRL;
        3'b110:  o_dec.aluFunc = ALU_OR;
        default: o_dec.aluFunc = ALU_AND;
      endcase
    end

    case (o_dec.iType)
      IT_BRANCH: begin
        case (w_funct3)
          3'b001:  o_dec.brFunc = BR_NE;
          3'b100:  o_dec.brFunc = BR_LT;
          3'b101:  o_dec.brFunc = BR_GE;
          3'b110:  o_dec.brFunc = BR_LTU;
          3'b111:  o_dec.brFunc = BR_GEU;
          default: o_dec.brFunc = BR_EQ;
        endcase
      end
      IT_JAL:  o_dec.brFunc = BR_JAL;
      IT_JALR: o_dec.brFunc = BR_JALR;
      default: o_dec.brFunc = BR_EQ;
    endcase
  end

endmodule

// File: rtl/dispatch_ctrl.sv
// In-order decode/dispatch controller.
// Ports:
//   clk_in, rst_n_in              clock, async active-low reset
//   fetch_valid_in/ready_out      fetch handshake; inst/pc carried alongside
//   disp_valid_out, disp_ready_in registered output stage; ready is per unit
//   disp_*_out                    decoded fields, PC and sequence tag
//   br_resolve_valid_in           outstanding branch resolved
//   br_mispredict_in              resolve requires redirect (flush)
//   flush_in                      external flush
// A small FIFO buffers fetch; its head is decoded and loaded into the output
// stage. After a branch-class dispatch no further loads happen until resolve.
module dispatch_ctrl
  import dispatch_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             fetch_valid_in,
  output logic             fetch_ready_out,
  input  logic [31:0]      fetch_inst_in,
  input  logic [31:0]      fetch_pc_in,
  output logic             disp_valid_out,
  input  logic [2:0]       disp_ready_in,
  output logic [1:0]       disp_unit_out,
  output logic [3:0]       disp_itype_out,
  output logic [3:0]       disp_alufunc_out,
  output logic [2:0]       disp_brfunc_out,
  output logic [31:0]      disp_imm_out,
  output logic [4:0]       disp_rs1_out,
  output logic [4:0]       disp_rs2_out,
  output logic [4:0]       disp_rd_out,
  output logic [31:0]      disp_pc_out,
  output logic [TAG_W-1:0] disp_tag_out,
  input  logic             br_resolve_valid_in,
  input  logic             br_mispredict_in,
  input  logic             flush_in
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [31:0]      r_instMem [DEPTH];
  logic [31:0]      r_pcMem   [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic [0:0]       r_state;
  logic [TAG_W-1:0] r_tagCnt;
  logic             r_valid;
  logic [1:0]       r_unit;
  decode_t          r_dec;
  logic [31:0]      r_pc;
  logic [TAG_W-1:0] r_tag;

  decode_t    w_headDec;
  logic       w_empty;
  logic       w_headNop;
  logic       w_unitReady;
  logic       w_transfer;
  logic       w_flush;
  logic       w_load;
  logic       w_drop;
  logic       w_pop;
  logic       w_push;
  logic [1:0] w_headUnit;

  dispatch_ctrl_decode u_decode (
    .i_inst (r_instMem[r_rptr]),
    .o_dec  (w_headDec)
  );

  assign w_empty    = (r_count == '0);
  assign w_headNop  = (w_headDec.iType == IT_NOP);
  assign w_headUnit = unitOf(w_headDec.iType);

  // Ready is selected by a case so an unused unit code never indexes past bit 2.
  always_comb begin
    w_unitReady = 1'b0;
    case (r_unit)
      UNIT_ALU: w_unitReady = disp_ready_in[0];
      UNIT_BR:  w_unitReady = disp_ready_in[1];
      UNIT_MEM: w_unitReady = disp_ready_in[2];
      default:  w_unitReady = 1'b0;
    endcase
  end

  assign w_transfer = r_valid && w_unitReady;
  assign w_flush    = flush_in ||
                      (r_state == ST_WAIT_BR && br_resolve_valid_in && br_mispredict_in);
  assign w_load     = (r_state == ST_RUN) && !w_empty && !w_headNop && !w_flush &&
                      (!r_valid || w_transfer);
  assign w_drop     = (r_state == ST_RUN) && !w_empty && w_headNop && !w_flush;
  assign w_pop      = w_load || w_drop;
  // Ready comes from the registered count only: no bypass when full.
  assign fetch_ready_out = (r_count != FULL_CNT);
  assign w_push     = fetch_valid_in && fetch_ready_out && !w_flush;

  // FIFO storage needs no reset; only pointers and count define its contents.
  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_instMem[r_wptr] <= fetch_inst_in;
      r_pcMem[r_wptr]   <= fetch_pc_in;
    end
  end

  // FIFO pointers and occupancy; flush discards everything including a same-cycle push.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  // Branch serialisation: a mispredict resolve is handled as a flush.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= ST_RUN;
    end else if (w_flush) begin
      r_state <= ST_RUN;
    end else if (r_state == ST_RUN) begin
      if (w_load && w_headUnit == UNIT_BR) r_state <= ST_WAIT_BR;
    end else if (br_resolve_valid_in) begin
      r_state <= ST_RUN;
    end
  end

  // Output stage; the tag counter keeps advancing across flushes.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_valid  <= 1'b0;
      r_unit   <= '0;
      r_dec    <= '0;
      r_pc     <= '0;
      r_tag    <= '0;
      r_tagCnt <= '0;
    end else if (w_flush) begin
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_valid  <= 1'b1;
      r_unit   <= w_headUnit;
      r_dec    <= w_headDec;
      r_pc     <= r_pcMem[r_rptr];
      r_tag    <= r_tagCnt;
      r_tagCnt <= r_tagCnt + 1'b1;
    end else if (w_transfer) begin
      r_valid <= 1'b0;
    end
  end

  assign disp_valid_out   = r_valid;
  assign disp_unit_out    = r_unit;
  assign disp_itype_out   = r_dec.iType;
  assign disp_alufunc_out = r_dec.aluFunc;
  assign disp_brfunc_out  = r_dec.brFunc;
  assign disp_imm_out     = r_dec.imm;
  assign disp_rs1_out     = r_dec.rs1;
  assign disp_rs2_out     = r_dec.rs2;
  assign disp_rd_out      = r_dec.rd;
  assign disp_pc_out      = r_pc;
  assign disp_tag_out     = r_tag;

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Directed testbench for dispatch_ctrl.
// Expected values are hand-computed from the RV32I encodings used below.
// iType codes: OP=1 OPIMM=2 BRANCH=5 LOAD=8.
module tb_dispatch_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        fetch_valid_in;
  logic        fetch_ready_out;
  logic [31:0] fetch_inst_in;
  logic [31:0] fetch_pc_in;
  logic        disp_valid_out;
  logic [2:0]  disp_ready_in;
  logic [1:0]  disp_unit_out;
  logic [3:0]  disp_itype_out;
  logic [3:0]  disp_alufunc_out;
  logic [2:0]  disp_brfunc_out;
  logic [31:0] disp_imm_out;
  logic [4:0]  disp_rs1_out;
  logic [4:0]  disp_rs2_out;
  logic [4:0]  disp_rd_out;
  logic [31:0] disp_pc_out;
  logic [3:0]  disp_tag_out;
  logic        br_resolve_valid_in;
  logic        br_mispredict_in;
  logic        flush_in;

  int totalChecks = 0;
  int badChecks   = 0;

  dispatch_ctrl #(.DEPTH(4), .TAG_W(4)) dut (
    .clk_in              (clk_in),
    .rst_n_in            (rst_n_in),
    .fetch_valid_in      (fetch_valid_in),
    .fetch_ready_out     (fetch_ready_out),
    .fetch_inst_in       (fetch_inst_in),
    .fetch_pc_in         (fetch_pc_in),
    .disp_valid_out      (disp_valid_out),
    .disp_ready_in       (disp_ready_in),
    .disp_unit_out       (disp_unit_out),
    .disp_itype_out      (disp_itype_out),
    .disp_alufunc_out    (disp_alufunc_out),
    .disp_brfunc_out     (disp_brfunc_out),
    .disp_imm_out        (disp_imm_out),
    .disp_rs1_out        (disp_rs1_out),
    .disp_rs2_out        (disp_rs2_out),
    .disp_rd_out         (disp_rd_out),
    .disp_pc_out         (disp_pc_out),
    .disp_tag_out        (disp_tag_out),
    .br_resolve_valid_in (br_resolve_valid_in),
    .br_mispredict_in    (br_mispredict_in),
    .flush_in            (flush_in)
  );

  always #5 clk_in = ~clk_in;

  // Advance one edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] inst, input logic [31:0] pc);
    fetch_valid_in = v;
    fetch_inst_in  = inst;
    fetch_pc_in    = pc;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalChecks++;
    assert (observed === expected)
    else begin
      badChecks++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst_n_in            = 1'b0;
    disp_ready_in       = 3'b111;
    br_resolve_valid_in = 1'b0;
    br_mispredict_in    = 1'b0;
    flush_in            = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0);
    #12;
    checkOutput("rst_valid", {31'b0, disp_valid_out}, 32'd0);
    checkOutput("rst_fready", {31'b0, fetch_ready_out}, 32'd1);
    checkOutput("rst_tag", {28'b0, disp_tag_out}, 32'd0);
    checkOutput("rst_pc", disp_pc_out, 32'd0);
    checkOutput("rst_imm", disp_imm_out, 32'd0);
    rst_n_in = 1'b1;
    tick();

    // Test 1: addi x1,x0,5
    $display("[TB] addi dispatch");
    applyStimulus(1'b1, 32'h00500093, 32'h100);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0);
    checkOutput("t1_notyet", {31'b0, disp_valid_out}, 32'd0);
    tick();
    checkOutput("t1_valid", {31'b0, disp_valid_out}, 32'd1);
    checkOutput("t1_unit", {30'b0, disp_unit_out}, 32'd0);
    checkOutput("t1_itype", {28'b0, disp_itype_out}, 32'd2);
    checkOutput("t1_alu", {28'b0, disp_alufunc_out}, 32'd0);
    checkOutput("t1_rd", {27'b0, disp_rd_out}, 32'd1);
    checkOutput("t1_imm", disp_imm_out, 32'd5);
    checkOutput("t1_pc", disp_pc_out, 32'h100);
    checkOutput("t1_tag", {28'b0, disp_tag_out}, 32'd0);
    tick();
    checkOutput("t1_drained", {31'b0, disp_valid_out}, 32'd0);

    // Test 2: beq then add, correct prediction
    $display("[TB] branch resolve ok");
    applyStimulus(1'b1, 32'h00000463, 32'h104);
    tick();
    applyStimulus(1'b1, 32'h002081B3, 32'h108);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0);
    checkOutput("t2_br_valid", {31'b0, disp_valid_out}, 32'd1);
    checkOutput("t2_br_unit", {30'b0, disp_unit_out}, 32'd1);
    checkOutput("t2_br_itype", {28'b0, disp_itype_out}, 32'd5);
    checkOutput("t2_br_imm", disp_imm_out, 32'd8);
    checkOutput("t2_br_tag", {28'b0, disp_tag_out}, 32'd1);
    tick();
    checkOutput("t2_wait1", {31'b0, disp_valid_out}, 32'd0);
    tick();
    checkOutput("t2_wait2", {31'b0, disp_valid_out}, 32'd0);
    br_resolve_valid_in = 1'b1;
    tick();
    br_resolve_valid_in = 1'b0;
    checkOutput("t2_resolve_edge", {31'b0, disp_valid_out}, 32'd0);
    tick();
    checkOutput("t2_add_valid", {31'b0, disp_valid_out}, 32'd1);
    checkOutput("t2_add_itype", {28'b0, disp_itype_out}, 32'd1);
    checkOutput("t2_add_rd", {27'b0, disp_rd_out}, 32'd3);
    checkOutput("t2_add_rs1", {27'b0, disp_rs1_out}, 32'd1);
    checkOutput("t2_add_rs2", {27'b0, disp_rs2_out}, 32'd2);
    checkOutput("t2_add_pc", disp_pc_out, 32'h108);
    checkOutput("t2_add_tag", {28'b0, disp_tag_out}, 32'd2);
    tick();

    // Test 3: beq then add, mispredict flushes the add
    $display("[TB] branch mispredict");
    applyStimulus(1'b1, 32'h00000463, 32'h200);
    tick();
    applyStimulus(1'b1, 32'h002081B3, 32'h204);
    disp_ready_in = 3'b000;
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0);
    checkOutput("t3_br_tag", {28'b0, disp_tag_out}, 32'd3);
    br_resolve_valid_in = 1'b1;
    br_mispredict_in    = 1'b1;
    tick();
    br_resolve_valid_in = 1'b0;
    br_mispredict_in    = 1'b0;
    disp_ready_in       = 3'b111;
    checkOutput("t3_flushed", {31'b0, disp_valid_out}, 32'd0);
    tick();
    tick();
    checkOutput("t3_no_add", {31'b0, disp_valid_out}, 32'd0);
    applyStimulus(1'b1, 32'h00500093, 32'h300);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("t3_next_valid", {31'b0, disp_valid_out}, 32'd1);
    checkOutput("t3_next_pc", disp_pc_out, 32'h300);
    checkOutput("t3_next_tag", {28'b0, disp_tag_out}, 32'd4);
    tick();

    // Test 5: invalid word dropped, lw dispatched
    $display("[TB] nop drop");
    applyStimulus(1'b1, 32'h00000000, 32'h400);
    tick();
    applyStimulus(1'b1, 32'h0000A283, 32'h404);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0);
    checkOutput("t5_nop_hidden", {31'b0, disp_valid_out}, 32'd0);
    tick();
    checkOutput("t5_lw_valid", {31'b0, disp_valid_out}, 32'd1);
    checkOutput("t5_lw_unit", {30'b0, disp_unit_out}, 32'd2);
    checkOutput("t5_lw_itype", {28'b0, disp_itype_out}, 32'd8);
    checkOutput("t5_lw_rd", {27'b0, disp_rd_out}, 32'd5);
    checkOutput("t5_lw_rs1", {27'b0, disp_rs1_out}, 32'd1);
    checkOutput("t5_lw_pc", disp_pc_out, 32'h404);
    checkOutput("t5_lw_tag", {28'b0, disp_tag_out}, 32'd5);
    tick();

    // Test 4: back-pressure fills stage plus FIFO, then in-order drain
    $display("[TB] backpressure");
    disp_ready_in = 3'b000;
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b1, 32'h00000013 | (32'(i) << 7) | (32'(i) << 20), 32'h500 + 32'(4 * i));
      tick();
    end
    checkOutput("t4_full", {31'b0, fetch_ready_out}, 32'd0);
    checkOutput("t4_hold_rd", {27'b0, disp_rd_out}, 32'd1);
    checkOutput("t4_hold_tag", {28'b0, disp_tag_out}, 32'd6);
    tick();
    checkOutput("t4_no_bypass", {27'b0, disp_rd_out}, 32'd1);
    applyStimulus(1'b0, 32'h0, 32'h0);
    disp_ready_in = 3'b111;
    for (int i = 2; i <= 5; i++) begin
      tick();
      checkOutput("t4_drain_valid", {31'b0, disp_valid_out}, 32'd1);
      checkOutput("t4_drain_rd", {27'b0, disp_rd_out}, 32'(i));
      checkOutput("t4_drain_pc", disp_pc_out, 32'h500 + 32'(4 * i));
      checkOutput("t4_drain_tag", {28'b0, disp_tag_out}, 32'(i + 5));
    end
    tick();
    checkOutput("t4_empty", {31'b0, disp_valid_out}, 32'd0);
    checkOutput("t4_fready", {31'b0, fetch_ready_out}, 32'd1);

    // Test 6: asynchronous reset mid-operation
    $display("[TB] async reset");
    disp_ready_in = 3'b000;
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 32'h00000013 | (32'(i) << 7), 32'h600 + 32'(4 * i));
      tick();
    end
    applyStimulus(1'b0, 32'h0, 32'h0);
    checkOutput("t6_pre_valid", {31'b0, disp_valid_out}, 32'd1);
    #2;
    rst_n_in = 1'b0;
    #1;
    checkOutput("t6_rst_valid", {31'b0, disp_valid_out}, 32'd0);
    checkOutput("t6_rst_pc", disp_pc_out, 32'd0);
    checkOutput("t6_rst_rd", {27'b0, disp_rd_out}, 32'd0);
    checkOutput("t6_rst_fready", {31'b0, fetch_ready_out}, 32'd1);
    #3;
    rst_n_in = 1'b1;
    tick();
    applyStimulus(1'b1, 32'h00500093, 32'h700);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("t6_tag_restart", {28'b0, disp_tag_out}, 32'd0);
    checkOutput("t6_pc", disp_pc_out, 32'h700);

    // External flush drops a same-cycle push; tag is not rewound
    $display("[TB] external flush");
    flush_in = 1'b1;
    applyStimulus(1'b1, 32'h00500093, 32'h800);
    tick();
    flush_in = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0);
    disp_ready_in = 3'b111;
    checkOutput("fl_valid", {31'b0, disp_valid_out}, 32'd0);
    tick();
    checkOutput("fl_push_dropped", {31'b0, disp_valid_out}, 32'd0);
    applyStimulus(1'b1, 32'h00500093, 32'h900);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("fl_next_pc", disp_pc_out, 32'h900);
    checkOutput("fl_next_tag", {28'b0, disp_tag_out}, 32'd1);
    tick();

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
